sdr_pixel_writer: RTL and testbench
===================================

SDR_PIXEL_WRITER -- requirements
Module: sdr_pixel_writer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_lcd is the clock, lcd_rst is the reset.
REQ-002 The block SHALL have parameter FRAME_WORDS, default 32640: number of 96-bit words per frame (480x272 pixels / 4).
REQ-003 The block SHALL have these ports:
- clk_lcd  in  1  clock; all logic on posedge
- lcd_rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse marking the start of a new frame
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  24  pixel as {R[23:16], G[15:8], B[7:0]}
- wr_data  out  96  packed word to the SDRAM write port
- wr_valid  out  1  wr_data holds an unaccepted word
- wr_ready  in  1  SDRAM write port accepts wr_data when wr_valid and wr_ready are both 1
- sdr_addr_set  out  1  one-cycle pulse that resets the SDRAM write address
- frame_done  out  1  one-cycle pulse after word FRAME_WORDS of the frame is accepted
- overflow  out  1  sticky flag: at least one packed word was dropped in the current frame

Function
REQ-004 The block SHALL have two states, IDLE and ACTIVE, and SHALL ignore pix_valid while in IDLE.
REQ-005 On frame_start in any state, the block SHALL enter ACTIVE, clear the pixel slot counter (0..3), clear the word counter, discard any partial word, clear wr_valid, and clear overflow.
REQ-006 sdr_addr_set SHALL be 1 in the cycle after frame_start and 0 otherwise.
REQ-007 In ACTIVE, each pix_valid cycle SHALL place the pixel in slot k and then advance k by 1, wrapping 3 to 0.
REQ-008 Slot k SHALL occupy wr_data bits [95-24k -: 24] as {B,G,R}; for example slot 0 is B=[95:88], G=[87:80], R=[79:72], and slot 3 is B=[23:16], G=[15:8], R=[7:0].
REQ-009 When the slot-3 pixel is accepted in cycle N, the completed word SHALL appear on wr_data with wr_valid=1 in cycle N+1.
REQ-010 wr_valid SHALL stay at 1 and wr_data SHALL stay stable until the handshake completes (wr_valid and wr_ready both 1 at posedge); wr_valid SHALL then fall unless a new word loads in that same cycle.
REQ-011 If a word completes while wr_valid=1 and wr_ready=1, the new word SHALL load with no bubble and wr_valid SHALL remain 1.
REQ-012 If a word completes while wr_valid=1 and wr_ready=0, the new word SHALL be dropped, the held word SHALL be kept, overflow SHALL be set to 1, and the word counter SHALL NOT advance.
REQ-013 The word counter SHALL increment on each handshake and SHALL saturate at FRAME_WORDS.
REQ-014 When the handshake of word FRAME_WORDS completes, frame_done SHALL pulse in the next cycle and the state SHALL return to IDLE; pixels arriving after that SHALL be ignored until the next frame_start.
REQ-015 If frame_start and pix_valid occur in the same cycle, frame_start SHALL take priority and that pixel SHALL become slot 0 of the new frame.
REQ-016 If frame_start and a handshake occur in the same cycle, the handshake SHALL count toward no frame and SHALL NOT generate frame_done.
REQ-017 wr_data SHALL hold its previous value when wr_valid=0; its content is don't-care in that case.

Reset
REQ-018 With lcd_rst=1 at a posedge, the block SHALL enter IDLE and set wr_data=0, wr_valid=0, sdr_addr_set=0, frame_done=0, overflow=0, slot counter=0 and word counter=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame: any pending word is discarded and no frame_done is generated.
REQ-020 After reset deasserts, the block SHALL ignore pixels until the first frame_start.

Verification
REQ-021 Packing: frame_start, then pixels 0x112233, 0x445566, 0x778899, 0xAABBCC with wr_ready=1 -> one cycle after the 4th pixel, wr_data=0x332211_665544_998877_CCBBAA and wr_valid=1 for 1 cycle.
REQ-022 Backpressure: wr_ready=0, 8 pixels streamed -> word 1 is held stable, word 2 is dropped, overflow=1; overflow clears on the next frame_start.
REQ-023 Full frame with FRAME_WORDS=4 (override), 16 pixels, wr_ready=1 -> 4 handshakes, then frame_done pulses once and the state is IDLE; a 17th pixel produces no output.
REQ-024 frame_start after 2 pixels -> the partial word is discarded, sdr_addr_set pulses 1 cycle later, and the next 4 pixels form a clean word in slot order.
REQ-025 lcd_rst asserted while wr_valid=1 -> the next cycle shows all outputs at 0 and no frame_done; pixels before the next frame_start are ignored.
REQ-026 Same-cycle frame_start and pix_valid=0xABCDEF -> 0xEFCDAB appears in wr_data[95:72] of the next word.

Source files
------------

// File: rtl/sdr_pixel_writer.sv
// rtl/sdr_pixel_writer.sv - packs 24-bit pixels four per 96-bit word for the SDRAM write port
module sdr_pixel_writer #(
  parameter int FRAME_WORDS = 32640
) (
  input  logic        clk_lcd,
  input  logic        lcd_rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic [95:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        sdr_addr_set,
  output logic        frame_done,
  output logic        overflow
);

  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [95:0] asm_q, asm_d;
  logic [95:0] wr_data_q, wr_data_d;
  logic        wr_valid_q, wr_valid_d;
  logic        sdr_addr_set_q, sdr_addr_set_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;
  logic        hs;
  logic [23:0] pix_sw;

  assign wr_data      = wr_data_q;
  assign wr_valid     = wr_valid_q;
  assign sdr_addr_set = sdr_addr_set_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;

  // Next-state: frame_start overrides everything, else handshake bookkeeping then pixel packing
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    word_cnt_d     = word_cnt_q;
    asm_d          = asm_q;
    wr_data_d      = wr_data_q;
    wr_valid_d     = wr_valid_q;
    sdr_addr_set_d = 1'b0;
    frame_done_d   = 1'b0;
    overflow_d     = overflow_q;
    hs             = wr_valid_q && wr_ready;
    // Pixel arrives as {R,G,B} but is stored as {B,G,R} in its slot
    pix_sw         = {pix_data[7:0], pix_data[15:8], pix_data[23:16]};

    if (frame_start) begin
      // A handshake in this cycle belongs to no frame, so it is not counted
      state_d        = ACTIVE;
      slot_d         = 2'd0;
      word_cnt_d     = '0;
      wr_valid_d     = 1'b0;
      overflow_d     = 1'b0;
      sdr_addr_set_d = 1'b1;
      if (pix_valid) begin
        asm_d[95:72] = pix_sw;
        slot_d       = 2'd1;
      end
    end else begin
      if (hs) begin
        wr_valid_d = 1'b0;
        if (word_cnt_q != LAST) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST - 1'b1) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      if (state_q == ACTIVE && pix_valid) begin
        slot_d = slot_q + 2'd1;
        case (slot_q)
          2'd0: asm_d[95:72] = pix_sw;
          2'd1: asm_d[71:48] = pix_sw;
          2'd2: asm_d[47:24] = pix_sw;
          default: begin
            // Output register free (or emptying now) takes the word; otherwise it is lost
            if (!wr_valid_q || hs) begin
              wr_data_d  = {asm_q[95:24], pix_sw};
              wr_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk_lcd) begin
    if (lcd_rst) begin
      state_q        <= IDLE;
      slot_q         <= 2'd0;
      word_cnt_q     <= '0;
      asm_q          <= '0;
      wr_data_q      <= '0;
      wr_valid_q     <= 1'b0;
      sdr_addr_set_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      word_cnt_q     <= word_cnt_d;
      asm_q          <= asm_d;
      wr_data_q      <= wr_data_d;
      wr_valid_q     <= wr_valid_d;
      sdr_addr_set_q <= sdr_addr_set_d;
      frame_done_q   <= frame_done_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sdr_pixel_writer.sv
// tb/tb_sdr_pixel_writer.sv - scoreboard bench for sdr_pixel_writer
module tb_sdr_pixel_writer;

  localparam int FW = 4;

  logic        clk_lcd = 1'b0;
  logic        lcd_rst, frame_start, pix_valid, wr_ready;
  logic [23:0] pix_data;
  logic [95:0] wr_data;
  logic        wr_valid, sdr_addr_set, frame_done, overflow;

  always #5 clk_lcd = ~clk_lcd;

  sdr_pixel_writer #(.FRAME_WORDS(FW)) dut (
    .clk_lcd(clk_lcd), .lcd_rst(lcd_rst), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .sdr_addr_set(sdr_addr_set),
    .frame_done(frame_done), .overflow(overflow)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state (transaction level)
  logic [95:0] exp_q[$];
  logic [23:0] m_pix[$];
  bit          m_active, m_pend, m_ovf, m_sas, m_done;
  int          m_cnt;

  function automatic logic [23:0] bgr(input logic [23:0] p);
    return {p[7:0], p[15:8], p[23:16]};
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every handshake must deliver the oldest predicted word
  always @(negedge clk_lcd) begin
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL handshake_word: got %h expected no word", wr_data);
      end else begin
        logic [95:0] w;
        w = exp_q.pop_front();
        if (wr_data !== w) begin
          fails++;
          $display("FAIL handshake_word: got %h expected %h", wr_data, w);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit fs, input bit pv, input logic [23:0] pd, input bit rdy);
    bit hs, was_active;
    lcd_rst = rst; frame_start = fs; pix_valid = pv; pix_data = pd; wr_ready = rdy;
    @(posedge clk_lcd);
    #1;
    hs = m_pend && rdy;
    was_active = m_active;
    if (rst || fs) begin
      // Pending word not taken this cycle is thrown away
      if (m_pend && !hs && exp_q.size() > 0) void'(exp_q.pop_back());
      m_pend = 0; m_ovf = 0; m_done = 0; m_cnt = 0;
      m_pix.delete();
      m_active = fs && !rst;
      m_sas = fs && !rst;
      if (fs && !rst && pv) m_pix.push_back(pd);
    end else begin
      m_sas = 0;
      m_done = 0;
      if (hs) begin
        m_pend = 0;
        if (m_cnt < FW) begin
          m_cnt++;
          if (m_cnt == FW) begin
            m_done = 1;
            m_active = 0;
          end
        end
      end
      if (was_active && pv) begin
        m_pix.push_back(pd);
        if (m_pix.size() == 4) begin
          logic [95:0] w;
          w = {bgr(m_pix[0]), bgr(m_pix[1]), bgr(m_pix[2]), bgr(m_pix[3])};
          m_pix.delete();
          if (!m_pend) begin
            exp_q.push_back(w);
            m_pend = 1;
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
    chk("wr_valid", {95'd0, wr_valid}, {95'd0, m_pend});
    chk("overflow", {95'd0, overflow}, {95'd0, m_ovf});
    chk("frame_done", {95'd0, frame_done}, {95'd0, m_done});
    chk("sdr_addr_set", {95'd0, sdr_addr_set}, {95'd0, m_sas});
    if (m_pend && exp_q.size() > 0) chk("wr_data_held", wr_data, exp_q[0]);
    if (rst) chk("wr_data_reset", wr_data, 96'd0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 24'h0, rdy);
  endtask

  initial begin
    step(1, 0, 0, 24'h0, 1);
    step(1, 0, 0, 24'h0, 1);
    // Pixels before the first frame_start are ignored
    step(0, 0, 1, 24'h123456, 1);
    idle(2, 1);

    // Packing
    step(0, 1, 0, 24'h0, 1);
    step(0, 0, 1, 24'h112233, 1);
    step(0, 0, 1, 24'h445566, 1);
    step(0, 0, 1, 24'h778899, 1);
    step(0, 0, 1, 24'hAABBCC, 1);
    chk("pack_word", wr_data, 96'h332211_665544_998877_CCBBAA);
    idle(3, 1);

    // Backpressure: second word dropped, first held
    step(0, 1, 0, 24'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 24'h100000 + 24'(i * 24'h010101), 0);
    idle(3, 0);
    chk("overflow_set", {95'd0, overflow}, 96'd1);
    step(0, 1, 0, 24'h0, 0);
    chk("overflow_clear", {95'd0, overflow}, 96'd0);

    // Full frame of FW words, then an ignored extra pixel
    step(0, 1, 0, 24'h0, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 24'($urandom), 1);
    idle(3, 1);
    step(0, 0, 1, 24'hDEAD01, 1);
    idle(6, 1);

    // Partial word discarded by a new frame_start
    step(0, 1, 0, 24'h0, 1);
    step(0, 0, 1, 24'h010203, 1);
    step(0, 0, 1, 24'h040506, 1);
    step(0, 1, 0, 24'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 24'h202020 + 24'(i), 1);
    idle(2, 1);

    // Reset while a word is pending
    step(0, 1, 0, 24'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 24'h303030 + 24'(i), 0);
    step(1, 0, 0, 24'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 24'h404040 + 24'(i), 1);
    idle(2, 1);

    // Same-cycle frame_start and pixel
    step(0, 1, 1, 24'hABCDEF, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 24'h505050 + 24'(i), 1);
    chk("fs_pixel_slot0", {72'd0, wr_data[95:72]}, {72'd0, 24'hEFCDAB});
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), 24'($urandom), ($urandom_range(0, 9) < 6));
    end
    idle(4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
